// File: rtl/mem_interface.sv
`default_nettype none
// ============================================================================
// Module  : mem_interface
// Word-addressed RAM behind a wait-state access sequencer with a done pulse.
// Optional out-of-range checking is enabled by defining MEM_BOUNDS_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================

module mem_interface #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int c_depth = 2 ** ADDR_WIDTH;
  localparam int c_cnt_w = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [c_cnt_w-1:0] c_wait_load =
    c_cnt_w'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam bit c_has_wait = (WAIT_STATES > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_write;
  logic                  r_oor;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic                  w_accept;
  logic                  w_oor_req;

  assign w_accept = Write | Read;

`ifdef MEM_BOUNDS_CHECK_EN
  assign w_oor_req = |address[31:ADDR_WIDTH];
`else
  // Upper address bits are deliberately dropped so accesses wrap.
  logic w_unused_addr;
  assign w_oor_req     = 1'b0;
  assign w_unused_addr = ^address[31:ADDR_WIDTH];
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_oor      <= 1'b0;
      r_data_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          if (w_accept) begin
            r_idx      <= address[ADDR_WIDTH-1:0];
            r_wdata    <= data_in;
            r_is_write <= Write;
            r_oor      <= w_oor_req;
            r_busy     <= 1'b1;
            if (c_has_wait) begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= c_wait_load;
            end else begin
              r_state    <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state <= ST_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt - c_cnt_w'(1);
          end
        end
        ST_ACCESS: begin
          // Out-of-range reads return zero rather than aliased data.
          if (!r_is_write) begin
            r_data_out <= r_oor ? '0 : r_mem[r_idx];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_error <= r_oor;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The array is not reset; an async clear returns the FSM to IDLE before any later edge.
  always_ff @(posedge clock) begin
    if ((r_state == ST_ACCESS) && r_is_write && !r_oor) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign data_out = r_data_out;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;

endmodule

`default_nettype wire
